// File: rtl/setuphold_monitor_if.sv
// setuphold_monitor_if: monitored inputs and violation reports of setuphold_monitor.
interface setuphold_monitor_if #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 8
);
   logic             en;
   logic             ref_clk;
   logic             mode;
   logic [N_CH-1:0]  data;
   logic             clr_count;
   logic [N_CH-1:0]  setup_viol;
   logic [N_CH-1:0]  hold_viol;
   logic             ntfr;
   logic [CNT_W-1:0] viol_count;
   modport master (
      output en, ref_clk, mode, data, clr_count,
      input  setup_viol, hold_viol, ntfr, viol_count
   );
   modport slave (
      input  en, ref_clk, mode, data, clr_count,
      output setup_viol, hold_viol, ntfr, viol_count
   );
endinterface

// File: rtl/setuphold_monitor.sv
// setuphold_monitor: clocked multi-channel setup/hold checker against a conditioned reference edge.
module setuphold_monitor #(
   parameter int N_CH     = 4,
   parameter int SETUP    = 2,
   parameter int HOLD     = 2,
   parameter int EDGE_SEL = 0,
   parameter int COND_POL = 1,
   parameter int CNT_W    = 8
) (
   input logic               clk,
   input logic               rst,
   setuphold_monitor_if.slave mon
);
   localparam int AMAX = SETUP > 1 ? SETUP : 1;
   localparam int AW   = $clog2(AMAX + 1);
   localparam int HW   = HOLD > 0 ? $clog2(HOLD + 1) : 1;
   localparam int W    = N_CH + 2;
   logic [W-1:0]              in_w, s_q, p_q;
   logic [N_CH-1:0][AW-1:0]   age_q, age_d;
   logic [HW-1:0]             hw_q, hw_d;
   logic [N_CH-1:0]           chg, sv_d, hv_d, setup_q, hold_q;
   logic                      rise, fall, ev, any_d, ntfr_q;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   assign in_w = {mon.ref_clk, mon.mode, mon.data};
   // age = cycles since the channel's last sampled change, saturating once it can no longer violate setup
   always_comb begin
      chg  = s_q[N_CH-1:0] ^ p_q[N_CH-1:0];
      rise = s_q[W-1] & ~p_q[W-1];
      fall = ~s_q[W-1] & p_q[W-1];
      ev   = mon.en && (s_q[W-2] == 1'(COND_POL)) &&
             (EDGE_SEL == 2 ? (rise | fall) : EDGE_SEL == 1 ? fall : rise);
      hw_d = !mon.en ? '0 : ev ? HW'(HOLD) : hw_q != '0 ? hw_q - 1'b1 : '0;
      for (int i = 0; i < N_CH; i++) begin
         sv_d[i]  = (SETUP > 0) && ev && (chg[i] || age_q[i] < AW'(SETUP));
         hv_d[i]  = mon.en && !ev && chg[i] && hw_q != '0;
         age_d[i] = chg[i] ? AW'(1) : age_q[i] == AW'(AMAX) ? age_q[i] : age_q[i] + 1'b1;
      end
      any_d = |{sv_d, hv_d};
      cnt_d = mon.clr_count ? '0 : (any_d && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q     <= in_w;
         p_q     <= in_w;
         age_q   <= {N_CH{AW'(AMAX)}};
         hw_q    <= '0;
         setup_q <= '0;
         hold_q  <= '0;
         ntfr_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         s_q     <= in_w;
         p_q     <= s_q;
         age_q   <= age_d;
         hw_q    <= hw_d;
         setup_q <= sv_d;
         hold_q  <= hv_d;
         ntfr_q  <= ntfr_q ^ any_d;
         cnt_q   <= cnt_d;
      end
   end
   assign mon.setup_viol = setup_q;
   assign mon.hold_viol  = hold_q;
   assign mon.ntfr       = ntfr_q;
   assign mon.viol_count = cnt_q;
endmodule

// File: tb/tb_setuphold_monitor.sv
// tb_setuphold_monitor: directed vector table, saturation/clear sequences and randomized run against a timestamp model.
module tb_setuphold_monitor;
   localparam int N_CH = 4, SETUP = 2, HOLD = 2, EDGE_SEL = 0, COND_POL = 1, CNT_W = 8;
   localparam int FAR = -100000;
   // control field {rst, en, ref_clk, mode, clr_count}
   localparam logic [4:0] RS0 = 5'b11010, RS1 = 5'b11110, R0 = 5'b01010, R1 = 5'b01110;
   localparam logic [4:0] M0R0 = 5'b01000, M0R1 = 5'b01100, EN0R1 = 5'b00110, CLR1 = 5'b01111;
   localparam logic [3:0] Z = 4'b0000;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int tests = 0, fails = 0;
   setuphold_monitor_if #(.N_CH(N_CH), .CNT_W(CNT_W)) mon();
   setuphold_monitor #(.N_CH(N_CH), .SETUP(SETUP), .HOLD(HOLD), .EDGE_SEL(EDGE_SEL),
                       .COND_POL(COND_POL), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .mon(mon));
   always #5 clk = ~clk;
   typedef struct {
      logic [4:0] ctl;
      logic [3:0] dat, sv, hv;
      logic       nt;
      logic [7:0] cnt;
   } vec_t;
   vec_t tbl[$];
   // timestamp model: t indexes detection cycles
   int t = 0, last_ev = FAR, last_enlow = FAR;
   int last_chg[N_CH];
   logic c_ref = 1'b0, p_ref = 1'b0, c_mode = 1'b0;
   logic [3:0] c_dat = '0, p_dat = '0;
   logic [3:0] e_sv = '0, e_hv = '0;
   logic e_nt = 1'b0;
   logic [7:0] e_cnt = '0;
   task automatic row(input logic [4:0] ctl, input logic [3:0] dat, sv, hv,
                      input logic nt, input logic [7:0] cnt);
      tbl.push_back('{ctl, dat, sv, hv, nt, cnt});
   endtask
   task automatic model_step(input logic r, e, rf, md, input logic [3:0] d, input logic c);
      logic [3:0] chg;
      logic rise, fall, ev;
      if (r) begin
         c_ref = rf; p_ref = rf; c_mode = md; c_dat = d; p_dat = d;
         e_sv = '0; e_hv = '0; e_nt = 1'b0; e_cnt = '0;
         last_ev = FAR;
         for (int i = 0; i < N_CH; i++) last_chg[i] = FAR;
      end else begin
         chg  = c_dat ^ p_dat;
         rise = c_ref && !p_ref;
         fall = !c_ref && p_ref;
         ev   = e && (c_mode == 1'(COND_POL)) &&
                (EDGE_SEL == 2 ? (rise || fall) : EDGE_SEL == 1 ? fall : rise);
         for (int i = 0; i < N_CH; i++) begin
            e_sv[i] = ev && SETUP > 0 && (chg[i] || t - last_chg[i] < SETUP);
            e_hv[i] = chg[i] && !ev && e && (t - last_ev >= 1) && (t - last_ev <= HOLD) &&
                      last_enlow < last_ev;
         end
         for (int i = 0; i < N_CH; i++) if (chg[i]) last_chg[i] = t;
         if (ev) last_ev = t;
         if (!e) last_enlow = t;
         if (|{e_sv, e_hv}) e_nt = !e_nt;
         if (c) e_cnt = '0;
         else if (|{e_sv, e_hv} && e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
         p_ref = c_ref; p_dat = c_dat;
         c_ref = rf; c_mode = md; c_dat = d;
      end
      t++;
   endtask
   task automatic apply(input logic [4:0] ctl, input logic [3:0] d);
      @(negedge clk);
      {rst, mon.en, mon.ref_clk, mon.mode, mon.clr_count} = ctl;
      mon.data = d;
      @(posedge clk);
      #1;
      model_step(ctl[4], ctl[3], ctl[2], ctl[1], d, ctl[0]);
   endtask
   task automatic check(input string name, input logic [3:0] sv, hv, input logic nt,
                        input logic [7:0] cnt);
      tests++;
      if ({mon.setup_viol, mon.hold_viol, mon.ntfr, mon.viol_count} !== {sv, hv, nt, cnt}) begin
         fails++;
         $display("FAIL %s: got sv=%b hv=%b ntfr=%b cnt=%0d, expected sv=%b hv=%b ntfr=%b cnt=%0d",
                  name, mon.setup_viol, mon.hold_viol, mon.ntfr, mon.viol_count, sv, hv, nt, cnt);
      end
   endtask
   initial begin
      logic [3:0] d;
      logic rf;
      {mon.en, mon.ref_clk, mon.mode, mon.clr_count} = 4'b1010;
      mon.data = '0;
      for (int i = 0; i < N_CH; i++) last_chg[i] = FAR;
      // reset, far change, near setup change
      row(RS0, 4'b0000, Z, Z, 1'b0, 8'd0);
      row(RS0, 4'b0000, Z, Z, 1'b0, 8'd0);
      row(R0, 4'b0001, Z, Z, 1'b0, 8'd0);
      for (int i = 0; i < 4; i++) row(R0, 4'b0001, Z, Z, 1'b0, 8'd0);
      row(R1, 4'b0001, Z, Z, 1'b0, 8'd0);
      row(R1, 4'b0001, Z, Z, 1'b0, 8'd0);
      row(R0, 4'b0001, Z, Z, 1'b0, 8'd0);
      row(R0, 4'b0001, Z, Z, 1'b0, 8'd0);
      row(R0, 4'b0011, Z, Z, 1'b0, 8'd0);
      row(R1, 4'b0011, Z, Z, 1'b0, 8'd0);
      row(R1, 4'b0011, 4'b0010, Z, 1'b1, 8'd1);
      row(R1, 4'b0011, Z, Z, 1'b1, 8'd1);
      // hold at d=2, none at d=3, window restart
      row(R0, 4'b0011, Z, Z, 1'b1, 8'd1);
      row(R1, 4'b0011, Z, Z, 1'b1, 8'd1);
      row(R1, 4'b0011, Z, Z, 1'b1, 8'd1);
      row(R1, 4'b0111, Z, Z, 1'b1, 8'd1);
      row(R1, 4'b0111, Z, 4'b0100, 1'b0, 8'd2);
      row(R0, 4'b0111, Z, Z, 1'b0, 8'd2);
      row(R1, 4'b0111, Z, Z, 1'b0, 8'd2);
      row(R1, 4'b0111, Z, Z, 1'b0, 8'd2);
      row(R1, 4'b0111, Z, Z, 1'b0, 8'd2);
      row(R1, 4'b0011, Z, Z, 1'b0, 8'd2);
      row(R1, 4'b0011, Z, Z, 1'b0, 8'd2);
      row(R0, 4'b0011, Z, Z, 1'b0, 8'd2);
      row(R1, 4'b0011, Z, Z, 1'b0, 8'd2);
      row(R0, 4'b0011, Z, Z, 1'b0, 8'd2);
      row(R1, 4'b0011, Z, Z, 1'b0, 8'd2);
      row(R1, 4'b0111, Z, Z, 1'b0, 8'd2);
      row(R1, 4'b0111, Z, 4'b0100, 1'b1, 8'd3);
      // mode=0, en=0, falling edge: no events
      row(M0R0, 4'b0111, Z, Z, 1'b1, 8'd3);
      row(M0R0, 4'b0101, Z, Z, 1'b1, 8'd3);
      row(M0R1, 4'b0101, Z, Z, 1'b1, 8'd3);
      row(M0R1, 4'b0101, Z, Z, 1'b1, 8'd3);
      row(M0R1, 4'b0101, Z, Z, 1'b1, 8'd3);
      row(R0, 4'b0101, Z, Z, 1'b1, 8'd3);
      row(R0, 4'b0111, Z, Z, 1'b1, 8'd3);
      row(EN0R1, 4'b0111, Z, Z, 1'b1, 8'd3);
      row(EN0R1, 4'b0111, Z, Z, 1'b1, 8'd3);
      row(R1, 4'b0111, Z, Z, 1'b1, 8'd3);
      row(R1, 4'b0101, Z, Z, 1'b1, 8'd3);
      row(R0, 4'b0101, Z, Z, 1'b1, 8'd3);
      row(R0, 4'b0101, Z, Z, 1'b1, 8'd3);
      // two channels change with the event: setup only
      row(R0, 4'b0101, Z, Z, 1'b1, 8'd3);
      row(R1, 4'b1100, Z, Z, 1'b1, 8'd3);
      row(R1, 4'b1100, 4'b1001, Z, 1'b0, 8'd4);
      row(R1, 4'b1100, Z, Z, 1'b0, 8'd4);
      // reset mid-window, ref high through release
      row(R0, 4'b1100, Z, Z, 1'b0, 8'd4);
      row(R1, 4'b1100, Z, Z, 1'b0, 8'd4);
      row(RS1, 4'b1100, Z, Z, 1'b0, 8'd0);
      row(R1, 4'b1101, Z, Z, 1'b0, 8'd0);
      row(R1, 4'b1101, Z, Z, 1'b0, 8'd0);
      // clear wins over a simultaneous violation
      row(R0, 4'b1101, Z, Z, 1'b0, 8'd0);
      row(R0, 4'b1111, Z, Z, 1'b0, 8'd0);
      row(R1, 4'b1111, Z, Z, 1'b0, 8'd0);
      row(CLR1, 4'b1111, 4'b0010, Z, 1'b1, 8'd0);
      row(R1, 4'b1111, Z, Z, 1'b1, 8'd0);
      foreach (tbl[i]) begin
         apply(tbl[i].ctl, tbl[i].dat);
         check($sformatf("vec%0d", i), tbl[i].sv, tbl[i].hv, tbl[i].nt, tbl[i].cnt);
      end
      d = '0;
      apply(RS0, d);
      check("sat_rst", e_sv, e_hv, e_nt, e_cnt);
      for (int n = 0; n < 300; n++) begin
         apply(R0, d);
         check($sformatf("sat%0d_a", n), e_sv, e_hv, e_nt, e_cnt);
         d[0] = !d[0];
         apply(R1, d);
         check($sformatf("sat%0d_b", n), e_sv, e_hv, e_nt, e_cnt);
      end
      apply(R0, d);
      check("sat_last", e_sv, e_hv, e_nt, e_cnt);
      tests++;
      if (mon.viol_count !== 8'hFF) begin
         fails++;
         $display("FAIL saturate: got cnt=%0d, expected cnt=255", mon.viol_count);
      end
      d[0] = !d[0];
      apply(R1, d);
      apply(CLR1, d);
      check("clr_viol", e_sv, e_hv, e_nt, e_cnt);
      tests++;
      if (mon.viol_count !== 8'd0 || mon.setup_viol !== 4'b0001) begin
         fails++;
         $display("FAIL clr_wins: got cnt=%0d sv=%b, expected cnt=0 sv=0001",
                  mon.viol_count, mon.setup_viol);
      end
      rf = 1'b0;
      d = '0;
      apply(RS0, d);
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(2) == 0) rf = !rf;
         for (int b = 0; b < N_CH; b++) if ($urandom_range(5) == 0) d[b] = !d[b];
         apply({$urandom_range(63) == 0, $urandom_range(7) != 0, rf,
                $urandom_range(5) != 0, $urandom_range(31) == 0}, d);
         check($sformatf("rand%0d", n), e_sv, e_hv, e_nt, e_cnt);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
